// File: rtl/uart_ram_loader.sv
// uart_ram_loader: AXI4-lite master that resets the UART FIFOs, then polls the
// UART status register and copies each received byte into a RAM window at
// consecutive byte addresses until the requested length has been stored.
// RAM_BYTES must be a power of two and at least 4 (one full word lane set).
module uart_ram_loader #(
  parameter int                    ADDR_WIDTH = 18,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] UART_BASE  = 18'h00000,
  parameter logic [ADDR_WIDTH-1:0] RAM_BASE   = 18'h10000,
  parameter int                    RAM_BYTES  = 65536
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [15:0]             load_len,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [15:0]             byte_count,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int OFF_W      = $clog2(RAM_BYTES);

  localparam logic [ADDR_WIDTH-1:0] UART_RX   = UART_BASE;
  localparam logic [ADDR_WIDTH-1:0] UART_STAT = UART_BASE + ADDR_WIDTH'(8);
  localparam logic [ADDR_WIDTH-1:0] UART_CTRL = UART_BASE + ADDR_WIDTH'(12);

  typedef enum logic [3:0] {
    IDLE, INIT_W, INIT_B, POLL_AR, POLL_R, RX_AR, RX_R, WR_W, WR_B, FIN
  } state_e;

  state_e                  state_q,   state_d;
  logic                    busy_q,    busy_d;
  logic                    done_q,    done_d;
  logic                    error_q,   error_d;
  logic [15:0]             count_q,   count_d;
  logic [15:0]             len_q,     len_d;
  logic [OFF_W-1:0]        offset_q,  offset_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q,  awaddr_d;
  logic                    awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0]   wdata_q,   wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q,   wstrb_d;
  logic                    wvalid_q,  wvalid_d;
  logic                    bready_q,  bready_d;
  logic [ADDR_WIDTH-1:0]   araddr_q,  araddr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q,  rready_d;

  logic aw_fire, w_fire;

  // Only the STAT ready bit and the RX byte lane carry information.
  logic unused_rdata;
  assign unused_rdata = ^m_axil_rdata[DATA_WIDTH-1:8];

  assign aw_fire = awvalid_q & m_axil_awready;
  assign w_fire  = wvalid_q  & m_axil_wready;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    // NOTE: every _d starts from its held value (done from 0) so no path through
    // the case statement leaves a variable unassigned and infers a latch.
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    count_d   = count_q;
    len_d     = len_q;
    offset_d  = offset_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d     = load_len;
          count_d   = '0;
          offset_d  = '0;
          error_d   = 1'b0;
          busy_d    = 1'b1;
          awaddr_d  = UART_CTRL;
          wdata_d   = DATA_WIDTH'(32'h3);
          wstrb_d   = '1;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          state_d   = INIT_W;
        end
      end

      // Address and data channels complete independently, in either order.
      INIT_W, WR_W: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if ((aw_fire || !awvalid_q) && (w_fire || !wvalid_q)) begin
          bready_d = 1'b1;
          state_d  = (state_q == INIT_W) ? INIT_B : WR_B;
        end
      end

      INIT_B, WR_B: begin
        if (m_axil_bvalid) begin
          bready_d = 1'b0;
          if (m_axil_bresp != 2'b00) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else if ((state_q == INIT_B && len_q == 16'd0) ||
                       (state_q == WR_B && count_q + 16'd1 == len_q)) begin
            if (state_q == WR_B) begin
              count_d  = count_q + 16'd1;
              offset_d = offset_q + OFF_W'(1);
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else begin
            if (state_q == WR_B) begin
              count_d  = count_q + 16'd1;
              offset_d = offset_q + OFF_W'(1);
            end
            araddr_d  = UART_STAT;
            arvalid_d = 1'b1;
            state_d   = POLL_AR;
          end
        end
      end

      POLL_AR, RX_AR: begin
        if (m_axil_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = (state_q == POLL_AR) ? POLL_R : RX_R;
        end
      end

      POLL_R, RX_R: begin
        if (m_axil_rvalid) begin
          rready_d = 1'b0;
          if (m_axil_rresp != 2'b00) begin
            error_d = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else if (state_q == RX_R) begin
            awaddr_d  = RAM_BASE + ADDR_WIDTH'(offset_q);
            wdata_d   = {STRB_WIDTH{m_axil_rdata[7:0]}};
            wstrb_d   = STRB_WIDTH'(1) << offset_q[1:0];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_W;
          end else begin
            // A ready RX FIFO moves on to the data read; otherwise re-poll at once.
            araddr_d  = m_axil_rdata[0] ? UART_RX : UART_STAT;
            arvalid_d = 1'b1;
            state_d   = m_axil_rdata[0] ? RX_AR : POLL_AR;
          end
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any in-flight transaction.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      count_q   <= '0;
      len_q     <= '0;
      offset_q  <= '0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      count_q   <= count_d;
      len_q     <= len_d;
      offset_q  <= offset_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign byte_count     = count_q;
  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_uart_ram_loader.sv
// Bench for uart_ram_loader: a behavioural AXI4-lite slave stands in for the
// UART and RAM, and each load is compared with a reference derived from the
// byte count, status-poll pattern, slave wait states and injected errors.
module tb_uart_ram_loader;

  localparam int          RAM_BYTES = 4;
  localparam logic [17:0] UART_BASE = 18'h00000;
  localparam logic [17:0] RAM_BASE  = 18'h10000;
  localparam logic [17:0] A_STAT    = UART_BASE + 18'd8;
  localparam logic [17:0] A_CTRL    = UART_BASE + 18'd12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] load_len = '0;
  logic        busy, done, error;
  logic [15:0] byte_count;
  logic [17:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        awready = 1'b0, wready = 1'b0, arready = 1'b0;
  logic        bvalid = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [31:0] rdata = '0;

  uart_ram_loader #(.RAM_BYTES(RAM_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .busy(busy), .done(done), .error(error), .byte_count(byte_count),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Slave configuration and bookkeeping
  typedef struct {
    logic [17:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } wr_t;

  int          aw_wait = 0, w_wait = 0, b_err_idx = -1, r_err_idx = -1;
  logic [7:0]  exp_bytes[$];
  int          exp_zeros[$];
  logic [7:0]  rx_q[$];
  int          zero_q[$];
  int          zero_left = 0;
  wr_t         wr_log[$];
  int          ram_wr_idx = 0, rx_idx = 0, stat_reads = 0, rx_reads = 0, init_writes = 0;
  logic [35:0] last_init = '0;
  int          aw_cnt = 0, w_cnt = 0, aw_hi = 0, w_hi = 0, last_aw_hi = 0, last_w_hi = 0;
  bit          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0, got_aw = 0, got_w = 0;
  bit          aw_stall = 0, w_stall = 0;
  logic [17:0] aw_addr_l = '0, ar_addr_l = '0, aw_stall_addr = '0;
  logic [31:0] w_data_l = '0;
  logic [3:0]  w_strb_l = '0;
  logic [35:0] w_stall_val = '0;

  // AXI4-lite slave: acts on the negative edge, one edge ahead of the DUT.
  always @(negedge clk) begin
    if (rst) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0; got_aw = 0; got_w = 0;
      aw_cnt = 0; w_cnt = 0; aw_hi = 0; w_hi = 0; aw_stall = 0; w_stall = 0;
    end else begin
      if (aw_stall) check("aw_stable", {awvalid, awaddr}, {1'b1, aw_stall_addr});
      if (w_stall)  check("w_stable", {wvalid, wstrb, wdata}, {1'b1, w_stall_val});
      if (aw_hs) got_aw = 1;
      if (w_hs)  got_w  = 1;
      if (b_hs)  bvalid = 0;
      if (r_hs)  rvalid = 0;
      if (ar_hs) begin
        rvalid = 1;
        rresp  = 2'b00;
        rdata  = $urandom;
        if (ar_addr_l == A_STAT) begin
          stat_reads++;
          if (zero_left > 0) begin
            rdata[0] = 1'b0;
            zero_left--;
          end else begin
            rdata[0] = 1'b1;
            zero_left = (zero_q.size() > 0) ? zero_q.pop_front() : 0;
          end
        end else begin
          rx_reads++;
          rdata[7:0] = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
          if (rx_idx == r_err_idx) rresp = 2'b10;
          rx_idx++;
        end
      end
      if (got_aw && got_w) begin
        got_aw = 0;
        got_w  = 0;
        bvalid = 1;
        bresp  = 2'b00;
        if (aw_addr_l == A_CTRL) begin
          init_writes++;
          last_init = {w_strb_l, w_data_l};
        end else begin
          wr_log.push_back('{addr: aw_addr_l, strb: w_strb_l, data: w_data_l});
          if (ram_wr_idx == b_err_idx) bresp = 2'b10;
          ram_wr_idx++;
        end
      end
      awready = awvalid && (aw_cnt >= aw_wait);
      wready  = wvalid  && (w_cnt  >= w_wait);
      arready = arvalid;
      aw_hs = awvalid && awready;
      w_hs  = wvalid  && wready;
      ar_hs = arvalid && arready;
      b_hs  = bvalid  && bready;
      r_hs  = rvalid  && rready;
      if (aw_hs) begin
        aw_addr_l = awaddr; aw_cnt = 0; last_aw_hi = aw_hi + 1; aw_hi = 0;
      end else if (awvalid) begin
        aw_cnt++; aw_hi++;
      end
      if (w_hs) begin
        w_data_l = wdata; w_strb_l = wstrb; w_cnt = 0; last_w_hi = w_hi + 1; w_hi = 0;
      end else if (wvalid) begin
        w_cnt++; w_hi++;
      end
      if (ar_hs) ar_addr_l = araddr;
      aw_stall      = awvalid && !awready;
      aw_stall_addr = awaddr;
      w_stall       = wvalid && !wready;
      w_stall_val   = {wstrb, wdata};
    end
  end

  task automatic prep_slave();
    rx_q = exp_bytes;
    zero_q = exp_zeros;
    zero_left = (zero_q.size() > 0) ? zero_q.pop_front() : 0;
    wr_log.delete();
    ram_wr_idx = 0; rx_idx = 0; stat_reads = 0; rx_reads = 0; init_writes = 0;
    last_init = '0;
  endtask

  // One complete load, compared with the reference outcome.
  task automatic run_load(input int len, input string tag);
    int cyc, exp_cyc, n_wr, n_ok, n_stat, n_rx, extra, z;
    bit exp_err;
    logic [17:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    prep_slave();
    extra = (aw_wait > w_wait) ? aw_wait : w_wait;
    exp_cyc = 3 + extra; n_wr = 0; n_ok = 0; n_stat = 0; n_rx = 0; exp_err = 0;
    for (int i = 0; i < len; i++) begin
      z = (i < exp_zeros.size()) ? exp_zeros[i] : 0;
      n_stat += z + 1;
      n_rx++;
      exp_cyc += 2 * (z + 1) + 2;
      if (i == r_err_idx) begin exp_err = 1; break; end
      n_wr++;
      exp_cyc += 2 + extra;
      if (i == b_err_idx) begin exp_err = 1; break; end
      n_ok++;
    end
    start = 1'b1;
    load_len = 16'(len);
    @(negedge clk); #1;
    start = 1'b0;
    load_len = 16'($urandom);
    cyc = 1;
    check({tag, ":start"}, {busy, error, awvalid, wvalid, done}, 5'b10110);
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
      if (cyc == 2) begin
        start = 1'b1;
        load_len = 16'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, ":done_cycle"}, cyc, exp_cyc);
    check({tag, ":done_busy"}, {done, busy}, 2'b10);
    check({tag, ":error"}, error, exp_err);
    check({tag, ":byte_count"}, byte_count, n_ok);
    check({tag, ":wr_count"}, wr_log.size(), n_wr);
    for (int i = 0; i < n_wr && i < wr_log.size(); i++) begin
      e_addr = RAM_BASE + 18'(i % RAM_BYTES);
      e_strb = 4'(1 << (i % 4));
      e_data = {4{exp_bytes[i]}};
      check($sformatf("%s:wr%0d", tag, i),
            {wr_log[i].addr, wr_log[i].strb, wr_log[i].data}, {e_addr, e_strb, e_data});
    end
    check({tag, ":stat_reads"}, stat_reads, n_stat);
    check({tag, ":rx_reads"}, rx_reads, n_rx);
    check({tag, ":init"}, {init_writes[3:0], last_init}, {4'd1, 4'hF, 32'h3});
    @(negedge clk); #1;
    check({tag, ":after_done"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int n;
    int len;

    // Power-on reset
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs",
          {busy, done, error, awvalid, wvalid, arvalid, bready, rready, awprot, arprot}, '0);
    check("reset_count", byte_count, 16'd0);
    rst = 1'b0;
    @(negedge clk); #1;

    // Three bytes, zero-wait slave
    exp_bytes = '{8'hA5, 8'h5A, 8'h3C};
    exp_zeros.delete();
    run_load(3, "t1");

    // Status not ready four times before the single byte
    exp_bytes = '{8'hC7};
    exp_zeros = '{4};
    run_load(1, "t2");

    // Write address held off for three cycles, write data immediate
    exp_bytes = '{8'h96};
    exp_zeros.delete();
    aw_wait = 3; w_wait = 0;
    run_load(1, "t3");
    check("t3:aw_hold", last_aw_hi, 4);
    check("t3:w_hold", last_w_hi, 1);
    aw_wait = 0;

    // SLVERR on the second RAM write, then a fresh start clears the flag
    exp_bytes = '{8'h01, 8'h02, 8'h03, 8'h04};
    b_err_idx = 1;
    run_load(4, "t4");
    b_err_idx = -1;
    repeat (3) @(negedge clk);
    #1;
    check("t4:sticky", {error, busy, done}, 3'b100);
    exp_bytes = '{8'hE1, 8'hE2};
    run_load(2, "t4_clear");

    // Offset wraps within a four-byte window
    exp_bytes = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    run_load(6, "t5");

    // Zero-length load goes straight to completion after the FIFO reset
    exp_bytes.delete();
    run_load(0, "t6");

    // Read error on the second RX FIFO access
    exp_bytes = '{8'h7E, 8'h81, 8'h99};
    r_err_idx = 1;
    run_load(3, "t7");
    r_err_idx = -1;

    // Reset while a RAM write is pending, then reset together with start
    exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    exp_zeros.delete();
    aw_wait = 20; w_wait = 20;
    prep_slave();
    start = 1'b1;
    load_len = 16'd5;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(awvalid === 1'b1 && awaddr >= RAM_BASE) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    check("t8:in_wr_w", {awvalid, wvalid, busy}, 3'b111);
    rst = 1'b1;
    @(negedge clk); #1;
    check("t8:rst_outputs", {busy, done, error, awvalid, wvalid, arvalid, bready, rready}, '0);
    check("t8:rst_count", byte_count, 16'd0);
    rst = 1'b1;
    start = 1'b1;
    load_len = 16'd7;
    @(negedge clk); #1;
    check("t8:rst_start", {busy, awvalid, wvalid}, 3'b000);
    rst = 1'b0;
    start = 1'b0;
    @(negedge clk); #1;
    check("t8:idle", {busy, awvalid, wvalid, arvalid}, 4'b0000);
    aw_wait = 0; w_wait = 0;
    exp_bytes = '{8'hAB, 8'hCD};
    run_load(2, "t8_new");

    // Randomized loads
    for (int k = 0; k < 8; k++) begin
      len = $urandom_range(1, 7);
      exp_bytes.delete();
      exp_zeros.delete();
      for (int i = 0; i < len; i++) begin
        exp_bytes.push_back(8'($urandom));
        exp_zeros.push_back($urandom_range(0, 2));
      end
      aw_wait = $urandom_range(0, 2);
      w_wait  = $urandom_range(0, 2);
      b_err_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, len - 1) : -1;
      run_load(len, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
    $fatal(1, "time limit");
  end

endmodule
